// File: rtl/mxm_result_collector_pkg.sv
// mxm_result_collector_pkg: shared MAC widths, log2 helper and result FIFO entry layout
package mxm_result_collector_pkg;
    localparam int MAC_W = 8;
    localparam int MAC_N = 1000;
    localparam int MAC_M = 4;
    localparam int MAC_P = 4;
    function automatic int log2(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction
    function automatic int entry_w(input int w, input int m, input int p);
        return w + log2(m) + log2(p) + 1;
    endfunction
    localparam int ENTRY_DATA_W = MAC_W;
    localparam int ENTRY_ROW_W = log2(MAC_M);
    localparam int ENTRY_COL_W = log2(MAC_P);
    localparam int ENTRY_LAST_W = 1;
    localparam int ENTRY_W = ENTRY_DATA_W + ENTRY_ROW_W + ENTRY_COL_W + ENTRY_LAST_W;
endpackage

// File: rtl/mxm_result_collector_fifo.sv
// result_fifo: synchronous FIFO with full/empty flags and concurrent push/pop
module result_fifo #(
    parameter int EW = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [EW-1:0] din,
    output logic [EW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);
    logic [EW-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic wr, rd;
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rd = pop && !empty;
    assign wr = push && (!full || rd);
    assign dout = mem[rp[AW-1:0]];
    // storage and pointers; a full push is only taken when the head leaves on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            mem <= '{default: '0};
        end else begin
            if (wr) begin
                mem[wp[AW-1:0]] <= din;
                wp <= wp + (AW+1)'(1);
            end
            if (rd) rp <= rp + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/mxm_result_collector.sv
// mxm_result_collector: samples MxM Y once per period, tags it with (row, col) and buffers it
module mxm_result_collector
    import mxm_result_collector_pkg::*;
#(
    parameter int W = MAC_W,
    parameter int N = MAC_N,
    parameter int M = MAC_M,
    parameter int P = MAC_P,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W-1:0]         y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic [log2(M)-1:0]   out_row,
    output logic [log2(P)-1:0]   out_col,
    output logic                 out_last,
    output logic                 overflow
);
    localparam int RW = log2(M);
    localparam int CW = log2(P);
    localparam int KW = log2(N);
    localparam int EW = entry_w(W, M, P);
    logic [KW-1:0] k;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic primed, cap, pop, full, empty, last, col_end;
    logic [EW-1:0] din, dout;
    assign cap = primed && (k == KW'(1));
    assign col_end = col == CW'(P - 1);
    assign last = (row == RW'(M - 1)) && col_end;
    assign pop = out_valid && out_ready;
    assign out_valid = !empty;
    assign din = {y, row, col, last};
    assign {out_data, out_row, out_col, out_last} = dout;
    // phase tracking mirrors MxM n; tags advance on every capture so dropped results keep alignment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= '0;
            primed <= 1'b0;
            row <= '0;
            col <= '0;
            overflow <= 1'b0;
        end else begin
            k <= (k == KW'(N - 1)) ? '0 : k + KW'(1);
            primed <= primed | (k == KW'(N - 1));
            overflow <= overflow | (cap && full && !pop);
            if (cap) begin
                col <= col_end ? '0 : col + CW'(1);
                if (col_end) row <= (row == RW'(M - 1)) ? '0 : row + RW'(1);
            end
        end
    end
    result_fifo #(.EW(EW), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(cap), .pop(pop),
        .din(din), .dout(dout), .full(full), .empty(empty)
    );
endmodule
